// File: rtl/pool_seq.sv
// pool_seq: address/strobe sequencer for 2x2 max-pooling of KERNELS feature
// maps, each IN_W x IN_W pixels, into IN_W/2 x IN_W/2 output maps.
//
// For every output pixel (window r,c of kernel k) the sequencer issues four
// reads (the 2x2 input window), one capture cycle, then one write. Each
// window takes exactly 6 cycles.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous, active-high reset
//   start     - request a full pooling run; sampled only in IDLE
//   busy      - high in READ, CAPT, WRITE, DONE
//   done      - one-cycle pulse after the last write
//   crd       - memory read strobe
//   caddr_rd  - read address (input map pixel)
//   cwr       - memory write strobe
//   caddr_wr  - write address (output map pixel)
//   csel      - bank select: 001/010 read kernel 0/1, 011/100 write kernel 0/1
//   en4mem    - one-hot capture enable for the window registers
//
// Strobe semantics: crd and cwr are single-cycle, fire-and-forget strobes
// with no back-pressure; the memory is assumed to accept every strobe in the
// cycle it is presented. crd and cwr are never high together, and csel is
// 000 whenever neither strobe is high.
module pool_seq #(
    parameter int KERNELS = 2,
    parameter int IN_W    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [2:0]  csel,
    output logic [3:0]  en4mem
);

    localparam int OW     = IN_W / 2;
    localparam int CW     = (OW > 1) ? $clog2(OW) : 1;
    localparam int IW_LOG = $clog2(IN_W);
    localparam logic [CW-1:0] C_LAST = CW'(OW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    logic          k;
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    logic [1:0]    p;

    logic [11:0] rd_addr;
    logic [11:0] wr_addr;

    // Input row = 2r + p[1], input column = 2c + p[0]. IN_W is a power of two
    // and the column is always < IN_W, so the sum reduces to shift-and-OR.
    assign rd_addr = (12'({r, p[1]}) << IW_LOG) | 12'({c, p[0]});
    assign wr_addr = (12'(r) << (IW_LOG - 1)) | 12'(c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= 1'b0;
            r      <= '0;
            c      <= '0;
            p      <= 2'd0;
            en4mem <= 4'b0000;
        end else begin
            // en4mem trails the read phase by one cycle: the captured data
            // for phase p is on cdata_rd the cycle after its read is issued.
            en4mem <= 4'b0000;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_READ;
                        k     <= 1'b0;
                        r     <= '0;
                        c     <= '0;
                        p     <= 2'd0;
                    end
                end
                S_READ: begin
                    en4mem <= 4'b0001 << p;
                    p      <= p + 2'd1;
                    if (p == 2'd3) begin
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_READ;
                    if (c != C_LAST) begin
                        c <= c + 1'b1;
                    end else if (r != C_LAST) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else if ((KERNELS == 2) && !k) begin
                        k <= 1'b1;
                        r <= '0;
                        c <= '0;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes, addresses and flags decode from registered state/counters
    // only; start never reaches an output combinationally.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        crd      = (state == S_READ);
        cwr      = (state == S_WRITE);
        csel     = 3'b000;
        caddr_rd = 12'd0;
        caddr_wr = 12'd0;
        if (state == S_READ) begin
            csel     = k ? 3'b010 : 3'b001;
            caddr_rd = rd_addr;
        end
        if (state == S_WRITE) begin
            csel     = k ? 3'b100 : 3'b011;
            caddr_wr = wr_addr;
        end
    end

endmodule

// File: tb/tb_pool_seq.sv
// tb_pool_seq: randomized scoreboard bench for pool_seq (KERNELS=2, IN_W=64).
// Expected memory transactions {is_write, csel, addr} are generated from the
// pooling rules and queued when a run is requested; a monitor pops and
// compares on every strobe and checks per-cycle invariants.
module tb_pool_seq;

    localparam int KERNELS   = 2;
    localparam int IN_W      = 64;
    localparam int OW        = IN_W / 2;
    localparam int RUN_CYC   = KERNELS * OW * OW * 6;
    localparam int RUN_WRITE = KERNELS * OW * OW;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [2:0]  csel;
    logic [3:0]  en4mem;

    logic [15:0] exp_q[$];
    int          checks;
    int          errors;

    pool_seq #(
        .KERNELS(KERNELS),
        .IN_W   (IN_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .crd     (crd),
        .caddr_rd(caddr_rd),
        .cwr     (cwr),
        .caddr_wr(caddr_wr),
        .csel    (csel),
        .en4mem  (en4mem)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, crd, cwr, caddr_rd, caddr_wr, csel, en4mem};
    endfunction

    // Reference model: window-by-window list of memory transactions.
    task automatic push_run();
        int addr;
        for (int kk = 0; kk < KERNELS; kk++) begin
            for (int rr = 0; rr < OW; rr++) begin
                for (int cc = 0; cc < OW; cc++) begin
                    for (int q = 0; q < 4; q++) begin
                        addr = (2 * rr + q / 2) * IN_W + 2 * cc + q % 2;
                        exp_q.push_back({1'b0, (kk == 0) ? 3'b001 : 3'b010, 12'(addr)});
                    end
                    addr = rr * OW + cc;
                    exp_q.push_back({1'b1, (kk == 0) ? 3'b011 : 3'b100, 12'(addr)});
                end
            end
        end
    endtask

    task automatic check_first_read(input string name);
        chk(name, {busy, crd, cwr, csel, caddr_rd}, {1'b1, 1'b1, 1'b0, 3'b001, 12'd0});
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(1, 6)) begin
            @(negedge clk);
            chk("idle_busy", {busy, done, crd, cwr}, 4'b0000);
        end
    endtask

    // Waits for done; optionally throws random start values at the busy DUT.
    task automatic wait_done(input bit rnd_start);
        bit found;
        found = 1'b0;
        for (int i = 0; i < RUN_CYC + 100; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                if (rnd_start) start = 1'b0;
                break;
            end
            if (rnd_start) start = 1'($urandom_range(0, 1));
        end
        chk("done_seen", found, 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          prev_phase = -1;
    int          rd_in_win  = 0;
    bit          run_active = 1'b0;
    int          run_cyc    = 0;
    int          writes     = 0;
    bit          after_done = 1'b0;
    logic [3:0]  exp_en;
    logic [15:0] e;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outs", all_outs(), 64'd0);
            prev_phase = -1;
            rd_in_win  = 0;
            run_active = 1'b0;
            after_done = 1'b0;
        end else begin
            if (after_done) begin
                chk("busy_after_done", {busy, done}, 2'b00);
                after_done = 1'b0;
            end
            chk("rd_wr_excl", crd & cwr, 1'b0);
            if (!crd && !cwr) chk("csel_idle", csel, 3'b000);
            chk("en4mem_onehot0", $onehot0(en4mem), 1'b1);
            exp_en = (prev_phase >= 0) ? (4'b0001 << prev_phase) : 4'b0000;
            chk("en4mem_phase", en4mem, exp_en);
            prev_phase = -1;
            if (run_active) run_cyc++;
            if (crd || cwr) begin
                if (!run_active && crd) begin
                    run_active = 1'b1;
                    run_cyc    = 0;
                    writes     = 0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {cwr, csel, cwr ? caddr_wr : caddr_rd}, 16'hffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn", {cwr, csel, cwr ? caddr_wr : caddr_rd}, e);
                end
                if (crd) begin
                    prev_phase = rd_in_win % 4;
                    rd_in_win++;
                end
                if (cwr) begin
                    rd_in_win = 0;
                    writes++;
                end
            end
            if (done) begin
                chk("done_strobes", {crd, cwr, csel, en4mem}, 9'd0);
                chk("done_cycle", run_cyc, RUN_CYC);
                chk("write_count", writes, RUN_WRITE);
                chk("queue_empty_at_done", exp_q.size(), 0);
                run_active = 1'b0;
                after_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", all_outs(), 64'd0);
        reset = 1'b0;
        idle_gap();

        // Run 1: single-cycle start pulse, random start noise while busy.
        push_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_first_read("run1_first_read");
        wait_done(1'b1);
        idle_gap();

        // Run 2: start held high; restart only after IDLE is re-entered.
        push_run();
        start = 1'b1;
        @(negedge clk);
        check_first_read("run2_first_read");
        wait_done(1'b0);
        #1 push_run();
        @(negedge clk);
        chk("idle_between_runs", {busy, crd}, 2'b00);
        @(negedge clk);
        check_first_read("restart_first_read");
        start = 1'b0;

        // Run 3: abort with reset during the write of window 10, kernel 0.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cwr && caddr_wr == 12'd10 && csel == 3'b011) begin
                found = 1'b1;
                break;
            end
        end
        chk("window10_write_seen", found, 1'b1);
        #1 reset = 1'b1;
        #1 chk("async_reset_outs", all_outs(), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_gap();

        // Run 4: after the abort, a new start begins at window 0 of kernel 0.
        push_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_first_read("post_reset_first_read");
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        chk("final_idle", {busy, done, crd, cwr}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_seq.md
POOL_SEQ -- requirements
Module: pool_seq

Interface
REQ-001 SHALL have parameter KERNELS, default 2, meaning number of feature maps pooled per start (legal values 1 or 2).
REQ-002 SHALL have parameter IN_W, default 64, meaning input map width and height in pixels (power of two, 4..64); output map is IN_W/2 square.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to pool all maps; sampled only in IDLE.
REQ-006 busy  output  1  sequence in progress.
REQ-007 done  output  1  one-cycle pulse when the last write is complete.
REQ-008 crd  output  1  memory read strobe.
REQ-009 caddr_rd  output  12  read address.
REQ-010 cwr  output  1  memory write strobe.
REQ-011 caddr_wr  output  12  write address.
REQ-012 csel  output  3  memory bank select.
REQ-013 en4mem  output  4  one-hot capture enable for the max-pool window registers; bit p captures cdata_rd for window pixel p.

Function
REQ-014 SHALL implement states IDLE, READ, CAPT, WRITE, DONE; outputs SHALL be decoded from registered state and counters only, with no combinational path from start.
REQ-015 IDLE: start=1 -> READ on the next edge with kernel k=0, row r=0, col c=0, phase p=0; start=0 -> stay.
REQ-016 READ: crd=1, caddr_rd=(2r+p[1])*IN_W+2c+p[0], csel=3'b001 for k=0 and 3'b010 for k=1; p increments each cycle; after p=3 -> CAPT.
REQ-017 en4mem SHALL be a one-cycle-delayed copy of the read phase: en4mem[p] is high in the cycle after the read of phase p is issued (READ cycles p=1..3 and CAPT), else 0.
REQ-018 CAPT: crd=0, cwr=0, en4mem=4'b1000; -> WRITE.
REQ-019 WRITE: cwr=1, caddr_wr=r*(IN_W/2)+c, csel=3'b011 for k=0 and 3'b100 for k=1, crd=0, en4mem=0.
REQ-020 After WRITE: c<IN_W/2-1 -> c+1, READ; c wraps to 0 and r+1 -> READ; last window with k<KERNELS-1 -> k+1, r=c=0, READ; last window of last kernel -> DONE.
REQ-021 Each window SHALL take exactly 6 cycles (4 READ, 1 CAPT, 1 WRITE); full run = KERNELS*(IN_W/2)^2*6 cycles from first READ to last WRITE.
REQ-022 DONE: done=1 for exactly one cycle, all strobes 0; -> IDLE.
REQ-023 busy SHALL be 1 in READ, CAPT, WRITE, DONE and 0 in IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued.
REQ-025 crd and cwr SHALL never be high in the same cycle; csel SHALL be 3'b000 whenever both strobes are 0.
REQ-026 Address arithmetic SHALL be unsigned, 12-bit; with IN_W=64, maximum caddr_rd=4095, maximum caddr_wr=1023.

Reset
REQ-027 reset=1 SHALL asynchronously force IDLE, k=r=c=p=0, busy=0, done=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, csel=3'b000, en4mem=4'b0000.
REQ-028 reset asserted mid-sequence SHALL abort without a done pulse or further write; the next start restarts from window 0 of kernel 0.

Verification
REQ-029 Bench SHALL pulse start for 1 cycle after reset -> next cycle busy=1, crd=1, csel=3'b001, caddr_rd=0; following reads 1, 64, 65; WRITE cycle cwr=1, caddr_wr=0, csel=3'b011.
REQ-030 Bench SHALL check window r=0,c=31 reads 62,63,126,127 and write 31; then window r=1,c=0 reads 128,129,192,193 and write 32.
REQ-031 Bench SHALL run to completion with KERNELS=2 -> exactly 2048 writes, kernel-1 writes on csel=3'b100 at 0..1023, done high once at cycle 12288 after first READ, busy falls the next cycle.
REQ-032 Bench SHALL hold start=1 continuously through a run -> no restart until IDLE; a new run begins the cycle after IDLE is re-entered.
REQ-033 Bench SHALL assert reset during the WRITE of window 10 -> all outputs 0 immediately, no done; a subsequent start reads address 0.
REQ-034 Bench SHALL check every cycle: en4mem one-hot or zero, en4mem[p] follows read phase p by one cycle, crd&cwr never both 1.
